mu_data_responder: RTL and testbench

- Responder side of the motion-update read interface.
- Serves the MU controller's per-particle read requests (rd_addr/rd_en).
- Each request fans out to the force, position and velocity caches of one home cell. Returns are latency-aligned into a single beat (home force, neighbour force, offset, velocity, element) and buffered against MU backpressure.
- Tracks the cell's particle count and signals completion of the per-cell read sweep.

---
 rtl/mu_data_responder_pkg.sv | 37 +++
 rtl/mu_rsp_skid_fifo.sv | 66 ++++++
 rtl/mu_data_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mu_data_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mu_data_responder_pkg.sv
// Shared MD payload types plus the motion-update response beat.
package mu_data_responder_pkg;

    localparam int unsigned PARTICLE_ID_WIDTH = 7;
    localparam int unsigned ELEMENT_WIDTH     = 2;
    localparam int unsigned FLOAT_WIDTH       = 32;
    localparam int unsigned OFFSET_WIDTH      = 32;

    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] x;
        logic [FLOAT_WIDTH-1:0] y;
        logic [FLOAT_WIDTH-1:0] z;
    } float_data_t;

    typedef struct packed {
        logic [OFFSET_WIDTH-1:0] offset_x;
        logic [OFFSET_WIDTH-1:0] offset_y;
        logic [OFFSET_WIDTH-1:0] offset_z;
    } offset_data_t;

    // One aligned response beat handed to the MU controller.
    typedef struct packed {
        float_data_t              home_frc;
        float_data_t              nb_frc;
        offset_data_t             offset;
        float_data_t              vel;
        logic [ELEMENT_WIDTH-1:0] element;
    } rsp_beat_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mu_rsp_skid_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module mu_rsp_skid_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr_c, do_rd_c;

    assign o_count   = count_q;
    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_rd_data = mem_q[rd_ptr_q];

    // A write into a full FIFO is allowed only when the head leaves the same cycle.
    always_comb begin
        do_rd_c  = i_rd_en && !o_empty;
        do_wr_c  = i_wr_en && (!o_full || do_rd_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_wr_c) - CNT_W'(do_rd_c);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/mu_data_responder.sv
// Motion-update read responder: fans requests out to the caches, aligns the
// returns into one beat and buffers beats against MU backpressure.
module mu_data_responder
    import mu_data_responder_pkg::*;
#(
    parameter int unsigned FRC_RD_LATENCY = 2,
    parameter int unsigned POS_RD_LATENCY = 1,
    parameter int unsigned VEL_RD_LATENCY = 1,
    parameter int unsigned SKID_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_rd_addr,
    input  logic                         i_rd_en,
    input  logic                         i_MU_buf_full,
    input  logic [PARTICLE_ID_WIDTH:0]   i_particle_num,
    input  logic                         i_particle_num_valid,
    output logic [PARTICLE_ID_WIDTH-1:0] o_frc_rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0] o_pos_rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0] o_vel_rd_addr,
    output logic                         o_frc_rd_en,
    output logic                         o_pos_rd_en,
    output logic                         o_vel_rd_en,
    input  float_data_t                  i_home_frc_rdata,
    input  float_data_t                  i_nb_frc_rdata,
    input  offset_data_t                 i_pos_rdata,
    input  logic [ELEMENT_WIDTH-1:0]     i_element_rdata,
    input  float_data_t                  i_vel_rdata,
    output float_data_t                  o_home_frc,
    output float_data_t                  o_nb_frc,
    output offset_data_t                 o_offset,
    output float_data_t                  o_vel,
    output logic [ELEMENT_WIDTH-1:0]     o_element,
    output logic                         o_data_valid,
    output logic                         o_rd_ready,
    output logic                         o_rd_done,
    output logic                         o_oob_err,
    output logic                         o_skid_overflow
);

    localparam int unsigned L       = max3(FRC_RD_LATENCY, POS_RD_LATENCY, VEL_RD_LATENCY);
    localparam int unsigned FRC_DLY = L - FRC_RD_LATENCY;
    localparam int unsigned POS_DLY = L - POS_RD_LATENCY;
    localparam int unsigned VEL_DLY = L - VEL_RD_LATENCY;
    localparam int unsigned FRC_W   = 2 * $bits(float_data_t);
    localparam int unsigned POS_W   = $bits(offset_data_t) + ELEMENT_WIDTH;
    localparam int unsigned VEL_W   = $bits(float_data_t);
    localparam int unsigned BEAT_W  = $bits(rsp_beat_t);
    localparam int unsigned FIFO_W  = BEAT_W + 1;
    localparam int unsigned FCNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int unsigned OCC_W   = $clog2(SKID_DEPTH + L + 2);
    localparam int unsigned PNUM_W  = PARTICLE_ID_WIDTH + 1;

    logic                         accept_c;
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr_c;
    logic [PNUM_W-1:0]            pnum_q, pnum_d;
    logic [PNUM_W-1:0]            cnt_q, cnt_d;
    logic                         epoch_q, epoch_d;
    logic                         done_q, done_d;
    logic                         oob_q, oob_d;
    logic                         ovf_q, ovf_d;
    logic                         run_q;
    logic [L-1:0]                 vld_q;
    logic [L-1:0]                 vepo_q;
    logic [FRC_W-1:0]             frc_al_c;
    logic [POS_W-1:0]             pos_al_c;
    logic [VEL_W-1:0]             vel_al_c;
    rsp_beat_t                    beat_al_c;
    rsp_beat_t                    out_beat_q, out_beat_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_epo_q, out_epo_d;
    logic                         consume_c, out_free_c, bypass_c, room_c, drop_c;
    logic                         fifo_push_c, fifo_pop_c;
    logic [FIFO_W-1:0]            fifo_rdata_c;
    logic [FCNT_W-1:0]            fifo_count_c;
    logic                         fifo_full_c, fifo_empty_c;
    logic [OCC_W-1:0]             inflight_c, occ_c, buf_occ_c;

    // Requests are only forwarded to the caches when inside the current cell.
    assign accept_c      = i_rd_en && (PNUM_W'(i_rd_addr) < pnum_q);
    assign rd_addr_c     = accept_c ? i_rd_addr : '0;
    assign o_frc_rd_en   = accept_c;
    assign o_pos_rd_en   = accept_c;
    assign o_vel_rd_en   = accept_c;
    assign o_frc_rd_addr = rd_addr_c;
    assign o_pos_rd_addr = rd_addr_c;
    assign o_vel_rd_addr = rd_addr_c;

    // In-flight tracker; each entry carries the sweep epoch it was issued in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            vepo_q <= '0;
        end else begin
            vld_q[0]  <= accept_c;
            vepo_q[0] <= epoch_q;
            for (int i = 1; i < L; i++) begin
                vld_q[i]  <= vld_q[i - 1];
                vepo_q[i] <= vepo_q[i - 1];
            end
        end
    end

    if (FRC_DLY == 0) begin : g_frc_direct
        assign frc_al_c = {i_home_frc_rdata, i_nb_frc_rdata};
    end else begin : g_frc_delay
        logic [FRC_W-1:0] frc_dly_q [FRC_DLY];
        // Retime force data onto the common alignment point.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < FRC_DLY; i++) frc_dly_q[i] <= '0;
            end else begin
                frc_dly_q[0] <= {i_home_frc_rdata, i_nb_frc_rdata};
                for (int i = 1; i < FRC_DLY; i++) frc_dly_q[i] <= frc_dly_q[i - 1];
            end
        end
        assign frc_al_c = frc_dly_q[FRC_DLY - 1];
    end

    if (POS_DLY == 0) begin : g_pos_direct
        assign pos_al_c = {i_pos_rdata, i_element_rdata};
    end else begin : g_pos_delay
        logic [POS_W-1:0] pos_dly_q [POS_DLY];
        // Retime offset and element data onto the common alignment point.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < POS_DLY; i++) pos_dly_q[i] <= '0;
            end else begin
                pos_dly_q[0] <= {i_pos_rdata, i_element_rdata};
                for (int i = 1; i < POS_DLY; i++) pos_dly_q[i] <= pos_dly_q[i - 1];
            end
        end
        assign pos_al_c = pos_dly_q[POS_DLY - 1];
    end

    if (VEL_DLY == 0) begin : g_vel_direct
        assign vel_al_c = i_vel_rdata;
    end else begin : g_vel_delay
        logic [VEL_W-1:0] vel_dly_q [VEL_DLY];
        // Retime velocity data onto the common alignment point.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < VEL_DLY; i++) vel_dly_q[i] <= '0;
            end else begin
                vel_dly_q[0] <= i_vel_rdata;
                for (int i = 1; i < VEL_DLY; i++) vel_dly_q[i] <= vel_dly_q[i - 1];
            end
        end
        assign vel_al_c = vel_dly_q[VEL_DLY - 1];
    end

    // Assemble the aligned beat from the retimed cache groups.
    always_comb begin
        beat_al_c = '0;
        {beat_al_c.home_frc, beat_al_c.nb_frc} = frc_al_c;
        {beat_al_c.offset, beat_al_c.element}  = pos_al_c;
        beat_al_c.vel                          = vel_al_c;
    end

    mu_rsp_skid_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (fifo_push_c),
        .i_wr_data ({vepo_q[L-1], beat_al_c}),
        .i_rd_en   (fifo_pop_c),
        .o_rd_data (fifo_rdata_c),
        .o_count   (fifo_count_c),
        .o_full    (fifo_full_c),
        .o_empty   (fifo_empty_c)
    );

    // Return path: output register refills from the FIFO head, or straight from
    // the aligned beat when the FIFO is empty; the output register counts toward
    // the SKID_DEPTH capacity so ready and overflow agree.
    always_comb begin
        consume_c   = out_valid_q && !i_MU_buf_full;
        out_free_c  = !out_valid_q || consume_c;
        fifo_pop_c  = out_free_c && !fifo_empty_c;
        bypass_c    = out_free_c && fifo_empty_c && vld_q[L-1];
        buf_occ_c   = OCC_W'(fifo_count_c) + OCC_W'(out_valid_q) - OCC_W'(consume_c);
        room_c      = !fifo_full_c && (buf_occ_c < OCC_W'(SKID_DEPTH));
        fifo_push_c = vld_q[L-1] && !bypass_c && room_c;
        drop_c      = vld_q[L-1] && !bypass_c && !room_c;
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        out_epo_d   = out_epo_q;
        if (out_free_c) begin
            if (!fifo_empty_c) begin
                {out_epo_d, out_beat_d} = fifo_rdata_c;
                out_valid_d             = 1'b1;
            end else if (vld_q[L-1]) begin
                out_beat_d  = beat_al_c;
                out_epo_d   = vepo_q[L-1];
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Sweep bookkeeping; beats from an older sweep epoch are delivered but not counted.
    always_comb begin
        pnum_d  = pnum_q;
        epoch_d = epoch_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        oob_d   = oob_q | (i_rd_en && !accept_c);
        ovf_d   = ovf_q | drop_c;
        if (i_particle_num_valid) begin
            pnum_d  = i_particle_num;
            epoch_d = ~epoch_q;
            cnt_d   = '0;
            done_d  = (i_particle_num == '0);
        end else if (consume_c && (out_epo_q == epoch_q)) begin
            if ((cnt_q + PNUM_W'(1)) == pnum_q) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PNUM_W'(1);
            end
        end
    end

    // State registers for the output beat, sweep tracking and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
            out_epo_q   <= 1'b0;
            pnum_q      <= '0;
            epoch_q     <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            oob_q       <= 1'b0;
            ovf_q       <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            out_epo_q   <= out_epo_d;
            pnum_q      <= pnum_d;
            epoch_q     <= epoch_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            oob_q       <= oob_d;
            ovf_q       <= ovf_d;
            run_q       <= 1'b1;
        end
    end

    // Ready reflects every beat already committed: in flight, queued or presented.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < L; i++) begin
            inflight_c = inflight_c + OCC_W'(vld_q[i]);
        end
        occ_c = inflight_c + OCC_W'(fifo_count_c) + OCC_W'(out_valid_q);
    end

    assign o_rd_ready      = run_q && (occ_c < OCC_W'(SKID_DEPTH));
    assign o_data_valid    = out_valid_q;
    assign o_home_frc      = out_beat_q.home_frc;
    assign o_nb_frc        = out_beat_q.nb_frc;
    assign o_offset        = out_beat_q.offset;
    assign o_vel           = out_beat_q.vel;
    assign o_element       = out_beat_q.element;
    assign o_rd_done       = done_q;
    assign o_oob_err       = oob_q;
    assign o_skid_overflow = ovf_q;

endmodule

// File: tb/tb_mu_data_responder.sv
// Scoreboard bench for mu_data_responder with behavioural cache models.
module tb_mu_data_responder;
    import mu_data_responder_pkg::*;

    localparam int unsigned PW  = PARTICLE_ID_WIDTH;
    localparam int unsigned PNW = PARTICLE_ID_WIDTH + 1;

    logic clk = 1'b0;
    logic rst;
    logic [PW-1:0] i_rd_addr;
    logic i_rd_en, i_MU_buf_full, i_particle_num_valid;
    logic [PNW-1:0] i_particle_num;
    logic [PW-1:0] o_frc_rd_addr, o_pos_rd_addr, o_vel_rd_addr;
    logic o_frc_rd_en, o_pos_rd_en, o_vel_rd_en;
    float_data_t i_home_frc_rdata, i_nb_frc_rdata, i_vel_rdata;
    offset_data_t i_pos_rdata;
    logic [ELEMENT_WIDTH-1:0] i_element_rdata;
    float_data_t o_home_frc, o_nb_frc, o_vel;
    offset_data_t o_offset;
    logic [ELEMENT_WIDTH-1:0] o_element;
    logic o_data_valid, o_rd_ready, o_rd_done, o_oob_err, o_skid_overflow;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int beats_seen = 0;
    rsp_beat_t sb[$];

    always #5 clk = ~clk;

    mu_data_responder dut (
        .clk(clk), .rst(rst),
        .i_rd_addr(i_rd_addr), .i_rd_en(i_rd_en), .i_MU_buf_full(i_MU_buf_full),
        .i_particle_num(i_particle_num), .i_particle_num_valid(i_particle_num_valid),
        .o_frc_rd_addr(o_frc_rd_addr), .o_pos_rd_addr(o_pos_rd_addr), .o_vel_rd_addr(o_vel_rd_addr),
        .o_frc_rd_en(o_frc_rd_en), .o_pos_rd_en(o_pos_rd_en), .o_vel_rd_en(o_vel_rd_en),
        .i_home_frc_rdata(i_home_frc_rdata), .i_nb_frc_rdata(i_nb_frc_rdata),
        .i_pos_rdata(i_pos_rdata), .i_element_rdata(i_element_rdata), .i_vel_rdata(i_vel_rdata),
        .o_home_frc(o_home_frc), .o_nb_frc(o_nb_frc), .o_offset(o_offset), .o_vel(o_vel),
        .o_element(o_element), .o_data_valid(o_data_valid), .o_rd_ready(o_rd_ready),
        .o_rd_done(o_rd_done), .o_oob_err(o_oob_err), .o_skid_overflow(o_skid_overflow)
    );

    // Cache contents as a function of particle address.
    function automatic rsp_beat_t exp_beat(input logic [PW-1:0] a);
        rsp_beat_t b;
        b = '0;
        b.home_frc.x      = 32'h3f800000;
        b.home_frc.y      = 32'(a);
        b.nb_frc.x        = 32'h40000000;
        b.nb_frc.z        = 32'(a);
        b.offset.offset_x = 32'h00400000 + 32'h00010000 * 32'(a);
        b.vel.x           = 32'h3e000000 + 32'(a);
        b.element         = 2'b01;
        return b;
    endfunction

    // Cache models: force latency 2, position and velocity latency 1.
    logic [PW-1:0] frc_a1 = '0, frc_a2 = '0, pos_a1 = '0, vel_a1 = '0;
    rsp_beat_t frc_b, pos_b, vel_b;
    always @(posedge clk) begin
        frc_a1 <= o_frc_rd_addr;
        frc_a2 <= frc_a1;
        pos_a1 <= o_pos_rd_addr;
        vel_a1 <= o_vel_rd_addr;
    end
    always_comb begin
        frc_b = exp_beat(frc_a2);
        pos_b = exp_beat(pos_a1);
        vel_b = exp_beat(vel_a1);
    end
    assign i_home_frc_rdata = frc_b.home_frc;
    assign i_nb_frc_rdata   = frc_b.nb_frc;
    assign i_pos_rdata      = pos_b.offset;
    assign i_element_rdata  = pos_b.element;
    assign i_vel_rdata      = vel_b.vel;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input int n);
        i_particle_num_valid = 1'b1;
        i_particle_num       = PNW'(n);
        tick();
        i_particle_num_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        check(tag, 128'(sb.size()), 128'(0));
    endtask

    // Output monitor: compare every presented beat with the scoreboard head.
    initial begin
        rsp_beat_t h;
        forever begin
            @(negedge clk);
            if (o_rd_done) done_seen++;
            if (o_data_valid) begin
                if (sb.size() == 0) begin
                    check("beat_unexpected", 128'(o_data_valid), 128'(0));
                end else begin
                    h = sb[0];
                    check("beat_home_frc", 128'(o_home_frc), 128'(h.home_frc));
                    check("beat_nb_frc", 128'(o_nb_frc), 128'(h.nb_frc));
                    check("beat_offset", 128'(o_offset), 128'(h.offset));
                    check("beat_vel", 128'(o_vel), 128'(h.vel));
                    check("beat_element", 128'(o_element), 128'(h.element));
                    if (!i_MU_buf_full) begin
                        void'(sb.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0;
        rst = 1'b1;
        i_rd_addr = '0;
        i_rd_en = 1'b0;
        i_MU_buf_full = 1'b0;
        i_particle_num = '0;
        i_particle_num_valid = 1'b0;
        tick();
        tick();
        check("rst_valid", 128'(o_data_valid), 128'(0));
        check("rst_ready", 128'(o_rd_ready), 128'(0));
        check("rst_done", 128'(o_rd_done), 128'(0));
        check("rst_oob", 128'(o_oob_err), 128'(0));
        check("rst_ovf", 128'(o_skid_overflow), 128'(0));
        check("rst_frc_en", 128'(o_frc_rd_en), 128'(0));
        rst = 1'b0;
        tick();
        tick();
        check("run_ready", 128'(o_rd_ready), 128'(1));

        // Basic single read: valid appears L+1 = 3 cycles after rd_en.
        latch(4);
        check("latch4_no_done", 128'(o_rd_done), 128'(0));
        i_rd_en = 1'b1;
        i_rd_addr = '0;
        sb.push_back(exp_beat(PW'(0)));
        #1;
        check("basic_frc_en", 128'(o_frc_rd_en), 128'(1));
        check("basic_pos_en", 128'(o_pos_rd_en), 128'(1));
        check("basic_vel_en", 128'(o_vel_rd_en), 128'(1));
        tick();
        i_rd_en = 1'b0;
        check("basic_c1_valid", 128'(o_data_valid), 128'(0));
        tick();
        check("basic_c2_valid", 128'(o_data_valid), 128'(0));
        tick();
        check("basic_c3_valid", 128'(o_data_valid), 128'(1));
        tick();
        check("basic_c4_valid", 128'(o_data_valid), 128'(0));
        check("basic_no_done", 128'(o_rd_done), 128'(0));
        tick();

        // Burst of four: back-to-back beats, done the cycle after the 4th.
        latch(4);
        for (int c = 0; c < 9; c++) begin
            i_rd_en = (c < 4);
            i_rd_addr = PW'(c % 4);
            if (c < 4) sb.push_back(exp_beat(PW'(c)));
            #1;
            if (c < 4) check("burst_vel_addr", 128'(o_vel_rd_addr), 128'(c));
            if (c >= 3 && c <= 6) check("burst_valid", 128'(o_data_valid), 128'(1));
            check("burst_done", 128'(o_rd_done), 128'(c == 7));
            tick();
        end

        // Backpressure for 5 cycles mid-burst.
        latch(4);
        d0 = done_seen;
        for (int c = 0; c < 10; c++) begin
            i_rd_en = (c < 4);
            i_rd_addr = PW'(c % 4);
            i_MU_buf_full = (c >= 4 && c <= 8);
            if (c < 4) sb.push_back(exp_beat(PW'(c)));
            tick();
        end
        i_rd_en = 1'b0;
        i_MU_buf_full = 1'b0;
        drain("bp_drain");
        tick();
        tick();
        check("bp_ovf", 128'(o_skid_overflow), 128'(0));
        check("bp_done_count", 128'(done_seen - d0), 128'(1));

        // Overflow: six requests while MU is full; only four fit.
        latch(4);
        d0 = done_seen;
        b0 = beats_seen;
        i_MU_buf_full = 1'b1;
        for (int c = 0; c < 9; c++) begin
            i_rd_en = (c < 6);
            i_rd_addr = PW'(c % 4);
            if (c < 4) sb.push_back(exp_beat(PW'(c)));
            #1;
            if (c < 6) check("ovf_ready", 128'(o_rd_ready), 128'(c < 4));
            if (c == 8) check("ovf_flag", 128'(o_skid_overflow), 128'(1));
            tick();
        end
        i_rd_en = 1'b0;
        i_MU_buf_full = 1'b0;
        drain("ovf_drain");
        repeat (4) tick();
        check("ovf_beats", 128'(beats_seen - b0), 128'(4));
        check("ovf_done_count", 128'(done_seen - d0), 128'(1));

        // Out-of-range request.
        check("oob_before", 128'(o_oob_err), 128'(0));
        i_rd_en = 1'b1;
        i_rd_addr = PW'(5);
        #1;
        check("oob_frc_en", 128'(o_frc_rd_en), 128'(0));
        check("oob_pos_en", 128'(o_pos_rd_en), 128'(0));
        check("oob_vel_en", 128'(o_vel_rd_en), 128'(0));
        tick();
        i_rd_en = 1'b0;
        check("oob_flag", 128'(o_oob_err), 128'(1));
        repeat (5) tick();

        // Reset with two reads in flight.
        latch(4);
        i_rd_en = 1'b1;
        i_rd_addr = PW'(1);
        sb.push_back(exp_beat(PW'(1)));
        tick();
        i_rd_addr = PW'(2);
        sb.push_back(exp_beat(PW'(2)));
        tick();
        i_rd_addr = '0;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mrst_valid", 128'(o_data_valid), 128'(0));
        check("mrst_ready", 128'(o_rd_ready), 128'(0));
        check("mrst_done", 128'(o_rd_done), 128'(0));
        check("mrst_oob", 128'(o_oob_err), 128'(0));
        check("mrst_ovf", 128'(o_skid_overflow), 128'(0));
        check("mrst_frc_en", 128'(o_frc_rd_en), 128'(0));
        check("mrst_home_frc", 128'(o_home_frc), 128'(0));
        check("mrst_offset", 128'(o_offset), 128'(0));
        i_rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("mrst_no_stale", 128'(o_data_valid), 128'(0));
        latch(0);
        check("zero_done", 128'(o_rd_done), 128'(1));
        tick();
        check("zero_done_pulse", 128'(o_rd_done), 128'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
